fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with redirect flush and response dropping.
// Define FETCH_BUF_EN to widen the holding register into a 2-entry prefetch FIFO.
module fetch_unit #(
  parameter int SIZE = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [SIZE-1:0] redirect_pc,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic [SIZE-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [SIZE-1:0] instruction,
  output logic [SIZE-1:0] PC,
  output logic [SIZE-1:0] PC_dec,
  output logic            stall_j
);
`ifdef FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [1:0]      out_cnt_q, out_cnt_d, fifo_cnt_q, fifo_cnt_d, kept;
  logic [SIZE-1:0] fw_q [DEPTH];
  logic [SIZE-1:0] fw_d [DEPTH];
  logic [SIZE-1:0] fp_q [DEPTH];
  logic [SIZE-1:0] fp_d [DEPTH];
  logic            slot_q, slot_d;
  logic [SIZE-1:0] instr_q, instr_d, pc_q, pc_d, pcd_q, pcd_d;
  logic [SIZE-1:0] aligned;
  logic            issue, resp, accept, load, pop, bypass, push;
  // fetch_pc tracks the next request, resp_pc the address of the next response
  assign aligned   = redirect_pc & ~SIZE'(3);
  assign issue     = state_q == REQ && !redirect && (out_cnt_q + fifo_cnt_q) < 2'(DEPTH);
  assign resp      = imem_valid && state_q != IDLE && out_cnt_q != 2'd0;
  assign accept    = resp && state_q == REQ && !redirect;
  assign load      = !slot_q || !stall;
  assign pop       = fifo_cnt_q != 2'd0 && load;
  assign bypass    = accept && fifo_cnt_q == 2'd0 && load;
  assign push      = accept && !bypass;
  assign kept      = fifo_cnt_q - 2'(pop);
  assign out_cnt_d = out_cnt_q + 2'(issue) - 2'(resp);
  assign fetch_pc_d = redirect ? aligned : issue ? fetch_pc_q + SIZE'(4) : fetch_pc_q;
  assign resp_pc_d  = redirect ? aligned : accept ? resp_pc_q + SIZE'(4) : resp_pc_q;
  assign state_d = state_q == IDLE ? REQ :
                   state_q == REQ  ? ((redirect && out_cnt_d != 2'd0) ? DROP : REQ) :
                   (out_cnt_d == 2'd0 ? REQ : DROP);
  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign PC          = pc_q;
  assign PC_dec      = pcd_q;
  assign stall_j     = redirect;
  always_comb begin
    fifo_cnt_d = redirect ? 2'd0 : kept + 2'(push);
    for (int i = 0; i < DEPTH; i++) begin
      fw_d[i] = (pop && i < DEPTH - 1) ? fw_q[(i < DEPTH - 1) ? i + 1 : i] : fw_q[i];
      fp_d[i] = (pop && i < DEPTH - 1) ? fp_q[(i < DEPTH - 1) ? i + 1 : i] : fp_q[i];
      fw_d[i] = (push && i == int'(kept)) ? imem_rdata : fw_d[i];
      fp_d[i] = (push && i == int'(kept)) ? resp_pc_q : fp_d[i];
    end
  end
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    slot_d  = slot_q;
    if (redirect) begin
      instr_d = '0;
      slot_d  = 1'b0;
    end else if (pop) begin
      instr_d = fw_q[0];
      pc_d    = fp_q[0];
      pcd_d   = fp_q[0] + SIZE'(4);
      slot_d  = 1'b1;
    end else if (bypass) begin
      instr_d = imem_rdata;
      pc_d    = resp_pc_q;
      pcd_d   = resp_pc_q + SIZE'(4);
      slot_d  = 1'b1;
    end else if (!stall) begin
      instr_d = '0;
      slot_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      slot_q     <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pcd_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fw_q[i] <= '0;
        fp_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      slot_q     <= slot_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pcd_q      <= pcd_d;
      fw_q       <= fw_d;
      fp_q       <= fp_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; an imem responder model feeds the fetch unit and
// expected (PC, word) pairs are queued when a live response is driven.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, stall_j, req1, sj1;
  logic [31:0] imem_addr, instruction, PC, PC_dec, addr1, ins1, pc1, pcd1;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction(instruction), .PC(PC), .PC_dec(PC_dec), .stall_j(stall_j)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction(ins1), .PC(pc1), .PC_dec(pcd1), .stall_j(sj1)
  );
  typedef struct {logic [31:0] addr; int due; int epoch;} pend_t;
  pend_t       pend[$];
  logic [63:0] sb[$];
  int          checks = 0, errors = 0, cyc = 0, lat = 1, epoch = 0, pres_cnt = 0, dead_cnt = 0;
  bit          cur_live = 1'b0;
  logic [31:0] cur_addr = '0, last_inst = '0, last_pc = '0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a < 32'd8 ? 32'h0050_0093 : a == 32'd8 ? 32'h0020_8133 : {a[29:0], 2'b11};
  endfunction
  task automatic monitor();
    logic [63:0] e;
    if (instruction != 0 && (last_inst == 0 || PC != last_pc)) begin
      pres_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr got pc=%h instr=%h, required none", PC, instruction);
      end else begin
        e = sb.pop_front();
        if ({PC, instruction} !== e || PC_dec !== e[63:32] + 32'd4) begin
          errors++;
          $display("FAIL present got pc=%h instr=%h pc_dec=%h, required pc=%h instr=%h pc_dec=%h",
                   PC, instruction, PC_dec, e[63:32], e[31:0], e[63:32] + 32'd4);
        end
      end
    end
    last_inst = instruction;
    last_pc = PC;
  endtask
  task automatic tick();
    logic r;
    logic [31:0] a;
    pend_t p;
    #1;
    r = imem_req;
    a = imem_addr;
    if (imem_valid && rst_n) begin
      if (cur_live && !redirect) sb.push_back({cur_addr, imem_rdata});
      else if (!cur_live) dead_cnt++;
    end
    @(posedge clk);
    cyc++;
    if (redirect) epoch++;
    if (r && rst_n) begin
      p.addr = a;
      p.due = cyc + lat - 1;
      p.epoch = epoch;
      pend.push_back(p);
    end
    #1;
    monitor();
    if (pend.size() > 0 && cyc >= pend[0].due) begin
      p = pend.pop_front();
      imem_valid = 1'b1;
      imem_rdata = mem(p.addr);
      cur_addr = p.addr;
      cur_live = (p.epoch == epoch);
    end else begin
      imem_valid = 1'b0;
      cur_live = 1'b0;
    end
  endtask
  task automatic wait_pres(input int n, input int lim, input string nm);
    int target = pres_cnt + n;
    int k = 0;
    while (pres_cnt < target && k < lim) begin
      tick();
      k++;
    end
    checks++;
    if (pres_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout got %0d presented, required %0d", nm, pres_cnt, target);
    end
  endtask
  task automatic hold_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    pend.delete();
    sb.delete();
    cur_live = 1'b0;
    epoch++;
    last_inst = '0;
    last_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    hold_reset();
    checks++;
    if ({instruction, PC, PC_dec} !== 96'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got instr=%h pc=%h pc_dec=%h req=%b, required all 0", instruction, PC, PC_dec, imem_req);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req got %b, required 0", imem_req);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
    end
  endtask
  task automatic test_seq();
    lat = 1;
    wait_pres(3, 30, "seq");
    checks++;
    if (PC !== 32'd8 || sb.size() != 0) begin
      errors++;
      $display("FAIL seq_end got pc=%h pending=%0d, required pc=8 pending=0", PC, sb.size());
    end
  endtask
  task automatic test_stall();
    stall = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (instruction !== 32'h0020_8133 || PC !== 32'd8 || PC_dec !== 32'd12) begin
        errors++;
        $display("FAIL stall_hold got instr=%h pc=%h pc_dec=%h, required 00208133/8/c", instruction, PC, PC_dec);
      end
    end
    stall = 1'b0;
    wait_pres(1, 10, "stall_release");
    checks++;
    if (PC !== 32'd12 || PC_dec !== 32'd16) begin
      errors++;
      $display("FAIL stall_next got pc=%h pc_dec=%h, required c/10", PC, PC_dec);
    end
  endtask
  task automatic test_redirect();
    int k = 0;
    int d0;
    lat = 3;
    while (pend.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    checks++;
    if (stall_j !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_strobe got stall_j=%b req=%b, required 1/0", stall_j, imem_req);
    end
    d0 = dead_cnt;
    tick();
    redirect = 1'b0;
    k = 0;
    while (!imem_req && k < 10) begin
      tick();
      k++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || dead_cnt <= d0 || pend.size() != 0) begin
      errors++;
      $display("FAIL redirect_drop got req=%b addr=%h dropped=%0d, required req=1 addr=100 dropped>0",
               imem_req, imem_addr, dead_cnt - d0);
    end
    lat = 1;
    wait_pres(1, 10, "redirect");
    checks++;
    if (PC !== 32'h100) begin
      errors++;
      $display("FAIL redirect_pc got %h, required 100", PC);
    end
  endtask
  task automatic test_redirect_valid();
    int k = 0;
    lat = 1;
    while (!(imem_valid && cur_live) && k < 20) begin
      tick();
      k++;
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instruction !== 32'h0) begin
      errors++;
      $display("FAIL redirect_valid got req=%b addr=%h instr=%h, required 1/200/0", imem_req, imem_addr, instruction);
    end
    wait_pres(1, 10, "redirect_valid");
    checks++;
    if (PC !== 32'h200) begin
      errors++;
      $display("FAIL redirect_valid_pc got %h, required 200", PC);
    end
  endtask
  task automatic test_wrap();
    int k = 0;
    hold_reset();
    rst_n = 1'b1;
    lat = 1;
    tick();
    checks++;
    if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first_req got req=%b addr=%h, required 1/fffffffc", req1, addr1);
    end
    wait_pres(1, 10, "wrap");
    checks++;
    if (pc1 !== 32'hFFFF_FFFC || pcd1 !== 32'h0 || ins1 !== 32'h0050_0093) begin
      errors++;
      $display("FAIL wrap_present got pc=%h pc_dec=%h instr=%h, required fffffffc/0/00500093", pc1, pcd1, ins1);
    end
    while (!req1 && k < 5) begin
      tick();
      k++;
    end
    checks++;
    if (req1 !== 1'b1 || addr1 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_second_req got req=%b addr=%h, required 1/0", req1, addr1);
    end
  endtask
  task automatic test_reset_mid();
    int k = 0;
    lat = 3;
    while (pend.size() == 0 && k < 20) begin
      tick();
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instruction, PC, PC_dec} !== 96'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got instr=%h pc=%h pc_dec=%h req=%b, required all 0", instruction, PC, PC_dec, imem_req);
    end
    hold_reset();
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    #1;
    checks++;
    if (instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL late_valid got instr=%h req=%b addr=%h, required 0/1/0", instruction, imem_req, imem_addr);
    end
    lat = 1;
    wait_pres(1, 10, "reset_mid");
    checks++;
    if (PC !== 32'h0 || instruction !== 32'h0050_0093) begin
      errors++;
      $display("FAIL reset_mid_first got pc=%h instr=%h, required 0/00500093", PC, instruction);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_seq();
    test_stall();
    test_redirect();
    test_redirect_valid();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
